// File: rtl/write_back_stage.sv
// Purpose    : registered write-back stage selecting ALU/mem/link/imm results for the register file and forwarding bus.
// Latency    : 1 cycle for non-load results; loads commit 1 cycle after mem_rvalid.
// Backpressure: in_ready drops while a load waits on memory (WAIT_MEM); flush kills the accept or the pending load.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid / in_ready      MEM-stage handshake; an instruction is taken when both are high and flush is low
//   flush                    rejects the same-cycle accept, abandons a pending load
//   src_data, src_sel        packed result sources (src i at [i*DW +: DW]) and their select
//   mem_load                 result comes from late memory data instead of src_data
//   mem_rdata, mem_rvalid    late load data and its strobe
//   write_register_in, reg_write_in   destination register and write intent
//   result_out, write_register_out, reg_write_out   register-file write port / forwarding bus
//   load_pending             stage is waiting on memory
//   mem_timeout              1-cycle pulse when a load is abandoned for lack of mem_rvalid
module write_back_stage #(
  parameter int DATA_WIDTH     = 22,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_SRC        = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int R0_HARDWIRED   = 1,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [SEL_WIDTH-1:0]          src_sel,
  input  logic                          mem_load,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_rvalid,
  input  logic [REG_ADDR_WIDTH-1:0]     write_register_in,
  input  logic                          reg_write_in,
  output logic [DATA_WIDTH-1:0]         result_out,
  output logic [REG_ADDR_WIDTH-1:0]     write_register_out,
  output logic                          reg_write_out,
  output logic                          load_pending,
  output logic                          mem_timeout
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t                    state, state_nxt;
  logic [7:0]                wait_cnt, wait_cnt_nxt;
  logic [DATA_WIDTH-1:0]     result_nxt;
  logic [REG_ADDR_WIDTH-1:0] wr_reg_nxt;
  logic                      reg_write_nxt;
  logic                      timeout_nxt;
  logic [REG_ADDR_WIDTH-1:0] pend_reg, pend_reg_nxt;
  logic                      pend_we, pend_we_nxt;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      accept;

  assign in_ready     = (state == IDLE);
  assign load_pending = (state == WAIT_MEM);
  assign accept       = in_valid & in_ready & ~flush;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(src_sel) == i) sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Write enable with register 0 suppression; the data path is unaffected.
  function automatic logic gate_we(input logic we, input logic [REG_ADDR_WIDTH-1:0] addr);
    gate_we = we & ~((R0_HARDWIRED != 0) && (addr == '0));
  endfunction

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    result_nxt    = result_out;
    wr_reg_nxt    = write_register_out;
    reg_write_nxt = 1'b0;
    timeout_nxt   = 1'b0;
    pend_reg_nxt  = pend_reg;
    pend_we_nxt   = pend_we;
    case (state)
      IDLE: begin
        // mem_rvalid here is either stray or from the accept cycle; neither belongs to a load.
        if (accept) begin
          if (mem_load) begin
            state_nxt    = WAIT_MEM;
            wait_cnt_nxt = '0;
            pend_reg_nxt = write_register_in;
            pend_we_nxt  = reg_write_in;
          end else begin
            result_nxt    = sel_data;
            wr_reg_nxt    = write_register_in;
            reg_write_nxt = gate_we(reg_write_in, write_register_in);
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          // flush wins over a simultaneous mem_rvalid
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (mem_rvalid) begin
          state_nxt     = IDLE;
          wait_cnt_nxt  = '0;
          result_nxt    = mem_rdata;
          wr_reg_nxt    = pend_reg;
          reg_write_nxt = gate_we(pend_we, pend_reg);
        end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
          timeout_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      result_out         <= '0;
      write_register_out <= '0;
      reg_write_out      <= 1'b0;
      mem_timeout        <= 1'b0;
      pend_reg           <= '0;
      pend_we            <= 1'b0;
    end else begin
      state              <= state_nxt;
      wait_cnt           <= wait_cnt_nxt;
      result_out         <= result_nxt;
      write_register_out <= wr_reg_nxt;
      reg_write_out      <= reg_write_nxt;
      mem_timeout        <= timeout_nxt;
      pend_reg           <= pend_reg_nxt;
      pend_we            <= pend_we_nxt;
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Purpose    : directed self-checking bench for write_back_stage (R0 hardwired and non-hardwired instances).
// Latency    : checks sampled 1 time unit after each rising edge.
// Backpressure: stimulus follows in_ready / load_pending as the directed scenarios expect.
module tb_write_back_stage;

  localparam int DW  = 22;
  localparam int AW  = 4;
  localparam int NS  = 4;
  localparam int SW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            flush;
  logic [NS*DW-1:0] src_data;
  logic [SW-1:0]   src_sel;
  logic            mem_load;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rvalid;
  logic [AW-1:0]   write_register_in;
  logic            reg_write_in;

  logic            in_ready, in_ready_b;
  logic [DW-1:0]   result_out, result_out_b;
  logic [AW-1:0]   write_register_out, write_register_out_b;
  logic            reg_write_out, reg_write_out_b;
  logic            load_pending, load_pending_b;
  logic            mem_timeout, mem_timeout_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  write_back_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_SRC(NS), .SEL_WIDTH(SW),
                     .R0_HARDWIRED(1), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .src_data(src_data), .src_sel(src_sel), .mem_load(mem_load), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .result_out(result_out), .write_register_out(write_register_out), .reg_write_out(reg_write_out),
    .load_pending(load_pending), .mem_timeout(mem_timeout)
  );

  write_back_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_SRC(NS), .SEL_WIDTH(SW),
                     .R0_HARDWIRED(0), .MEM_TIMEOUT(15)) dut_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .flush(flush),
    .src_data(src_data), .src_sel(src_sel), .mem_load(mem_load), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .result_out(result_out_b), .write_register_out(write_register_out_b), .reg_write_out(reg_write_out_b),
    .load_pending(load_pending_b), .mem_timeout(mem_timeout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; mem_load = 1'b0; mem_rvalid = 1'b0;
    reg_write_in = 1'b0;
  endtask

  task automatic alu_op(input logic [SW-1:0] sel, input logic [AW-1:0] rd);
    in_valid = 1'b1; mem_load = 1'b0; src_sel = sel;
    write_register_in = rd; reg_write_in = 1'b1;
  endtask

  task automatic load_op(input logic [AW-1:0] rd);
    in_valid = 1'b1; mem_load = 1'b1; src_sel = 2'd1;
    write_register_in = rd; reg_write_in = 1'b1;
  endtask

  // Directed vectors for the back-to-back run: select, destination, expected result.
  logic [SW-1:0] b2b_sel [4] = '{2'd0, 2'd2, 2'd3, 2'd1};
  logic [AW-1:0] b2b_rd  [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
  logic [DW-1:0] b2b_exp [4] = '{22'h0ABCD, 22'h2AAAA, 22'h15555, 22'h01111};

  initial begin
    rst = 1'b1;
    idle_inputs();
    src_sel = '0; write_register_in = '0; mem_rdata = '0;
    src_data = {22'h15555, 22'h2AAAA, 22'h01111, 22'h0ABCD};
    tick(); tick();
    check("rst_result",  32'(result_out), 32'h0);
    check("rst_wr_reg",  32'(write_register_out), 32'h0);
    check("rst_we",      32'(reg_write_out), 32'h0);
    check("rst_pending", 32'(load_pending), 32'h0);
    check("rst_timeout", 32'(mem_timeout), 32'h0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(in_ready), 32'h1);

    // 1. ALU op from src0 into r5.
    alu_op(2'd0, 4'd5);
    tick();
    idle_inputs();
    check("alu_result", 32'(result_out), 32'h0ABCD);
    check("alu_wr_reg", 32'(write_register_out), 32'h5);
    check("alu_we",     32'(reg_write_out), 32'h1);
    tick();
    check("alu_we_pulse", 32'(reg_write_out), 32'h0);
    check("alu_hold",     32'(result_out), 32'h0ABCD);

    // 2. Load into r3; rvalid in the accept cycle is ignored; data arrives on the 4th wait cycle.
    load_op(4'd3);
    mem_rvalid = 1'b1; mem_rdata = 22'h00BAD;
    tick();
    idle_inputs();
    check("ld_pending", 32'(load_pending), 32'h1);
    check("ld_ready",   32'(in_ready), 32'h0);
    check("ld_no_we",   32'(reg_write_out), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ld_wait_pending", 32'(load_pending), 32'h1);
      check("ld_wait_ready",   32'(in_ready), 32'h0);
    end
    mem_rvalid = 1'b1; mem_rdata = 22'h3FFFF;
    tick();
    mem_rvalid = 1'b0;
    check("ld_result",  32'(result_out), 32'h3FFFF);
    check("ld_wr_reg",  32'(write_register_out), 32'h3);
    check("ld_we",      32'(reg_write_out), 32'h1);
    check("ld_ready_at_commit", 32'(in_ready), 32'h1);
    tick();
    check("ld_we_pulse", 32'(reg_write_out), 32'h0);

    // 3. Load with no data: timeout after 15 waiting cycles.
    load_op(4'd7);
    tick();
    idle_inputs();
    for (int i = 1; i < 15; i++) begin
      tick();
      check("to_still_pending", 32'(load_pending), 32'h1);
      check("to_not_yet",       32'(mem_timeout), 32'h0);
    end
    tick();
    check("to_pulse",   32'(mem_timeout), 32'h1);
    check("to_no_we",   32'(reg_write_out), 32'h0);
    check("to_ready",   32'(in_ready), 32'h1);
    check("to_hold",    32'(result_out), 32'h3FFFF);
    tick();
    check("to_pulse_end", 32'(mem_timeout), 32'h0);

    // 4. flush with simultaneous rvalid, then a stray rvalid in IDLE.
    load_op(4'd9);
    tick();
    idle_inputs();
    tick();
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 22'h12345;
    tick();
    check("fl_no_we",   32'(reg_write_out), 32'h0);
    check("fl_idle",    32'(load_pending), 32'h0);
    check("fl_hold",    32'(result_out), 32'h3FFFF);
    flush = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    check("stray_no_we", 32'(reg_write_out), 32'h0);
    check("stray_hold",  32'(result_out), 32'h3FFFF);
    alu_op(2'd0, 4'd6); flush = 1'b1;
    tick();
    idle_inputs();
    check("fl_reject_we", 32'(reg_write_out), 32'h0);

    // 5. Write to r0: suppressed when hardwired, pulses otherwise; data still updates.
    src_data[DW-1:0] = 22'h00155;
    alu_op(2'd0, 4'd0);
    tick();
    idle_inputs();
    check("r0_we_hard",   32'(reg_write_out), 32'h0);
    check("r0_result",    32'(result_out), 32'h00155);
    check("r0_we_soft",   32'(reg_write_out_b), 32'h1);
    src_data[DW-1:0] = 22'h0ABCD;

    // 6. Back-to-back ALU ops, one commit per cycle in order.
    for (int i = 0; i < 4; i++) begin
      alu_op(b2b_sel[i], b2b_rd[i]);
      tick();
      check("b2b_result", 32'(result_out), 32'(b2b_exp[i]));
      check("b2b_wr_reg", 32'(write_register_out), 32'(b2b_rd[i]));
      check("b2b_we",     32'(reg_write_out), 32'h1);
    end
    idle_inputs();

    // Reset while waiting on a load discards it.
    load_op(4'd10);
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_result",  32'(result_out), 32'h0);
    check("mid_rst_wr_reg",  32'(write_register_out), 32'h0);
    check("mid_rst_we",      32'(reg_write_out), 32'h0);
    check("mid_rst_pending", 32'(load_pending), 32'h0);
    check("mid_rst_timeout", 32'(mem_timeout), 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 22'h2BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("post_rst_no_we",  32'(reg_write_out), 32'h0);
    check("post_rst_result", 32'(result_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
